// File: rtl/cic_comb_scheduler_pkg.sv
// Shared types and sizing helpers for the CIC decimation controller and comb engine.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int NSTAGES = 3;
  localparam int STAGE_W = $clog2(NSTAGES);

  // A single channel still needs a one-bit index so the array selects stay legal.
  function automatic int ch_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int cic_out_width(input int in_width, input int m);
    return in_width + $clog2(m * m * m);
  endfunction

endpackage

// File: rtl/cic_comb_scheduler_if.sv
// Sample-strobe input, decimated-frame output and status bundle of the comb scheduler.
interface cic_comb_scheduler_if #(
  parameter int NCH   = 2,
  parameter int WIDTH = 24
);
  logic                 in_valid;
  logic [NCH*WIDTH-1:0] integ;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic                 busy;
  logic                 overrun;
  logic                 clear_overrun;

  modport master (
    output in_valid, integ, out_ready, clear_overrun,
    input  out_valid, out_data, busy, overrun
  );

  modport slave (
    input  in_valid, integ, out_ready, clear_overrun,
    output out_valid, out_data, busy, overrun
  );
endinterface

// File: rtl/cic_comb_scheduler_phase.sv
// Modulo-M input-sample counter; boundary marks the strobe that completes a decimation period.
module cic_phase_counter #(
  parameter int M = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [$clog2(M)-1:0] phase,
  output logic                 boundary
);
  localparam int PW = $clog2(M);
  localparam logic [PW-1:0] LAST = PW'(M - 1);

  assign boundary = en && (phase == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (en) begin
      phase <= boundary ? '0 : phase + PW'(1);
    end
  end
endmodule

// File: rtl/cic_comb_scheduler.sv
// Decimation controller with one shared subtractor running NCH channels x 3 comb stages,
// presenting each decimated frame on a valid/ready output.
module cic_comb_scheduler
  import cic_pkg::*;
#(
  parameter int M     = 8,
  parameter int NCH   = 2,
  parameter int WIDTH = 24
) (
  input logic                 clk,
  input logic                 reset,
  cic_comb_scheduler_if.slave bus
);
  localparam int CW = ch_idx_w(NCH);
  localparam int PW = $clog2(M);
  localparam logic [CW-1:0]      LAST_CH    = CW'(NCH - 1);
  localparam logic [STAGE_W-1:0] LAST_STG   = STAGE_W'(NSTAGES - 1);
  localparam logic [PW-1:0]      LAST_PHASE = PW'(M - 1);

  state_t               state, state_d;
  logic [CW-1:0]        ch, ch_d;
  logic [STAGE_W-1:0]   stg, stg_d;
  logic [PW-1:0]        phase;
  logic                 boundary;
  logic                 take;
  logic                 drop;
  logic                 overrun;
  logic [WIDTH-1:0]     cap   [NCH];
  logic [WIDTH-1:0]     d_del [NCH][NSTAGES];
  logic [WIDTH-1:0]     dout  [NCH];
  logic [WIDTH-1:0]     y_chain;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;

  cic_phase_counter #(.M(M)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.in_valid),
    .phase    (phase),
    .boundary (boundary)
  );

  always_ff @(posedge clk) begin
    if (!reset && boundary) begin
      assert (phase == LAST_PHASE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ch    <= '0;
      stg   <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
      stg   <= stg_d;
    end
  end

  // A boundary in OUT is only usable when the frame leaves in the same cycle.
  always_comb begin
    state_d = state;
    ch_d    = ch;
    stg_d   = stg;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (boundary) begin
          take    = 1'b1;
          state_d = RUN;
          ch_d    = '0;
          stg_d   = '0;
        end
      end
      RUN: begin
        if (stg == LAST_STG) begin
          stg_d = '0;
          if (ch == LAST_CH) state_d = OUT;
          else               ch_d    = ch + CW'(1);
        end else begin
          stg_d = stg + STAGE_W'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          if (boundary) begin
            take    = 1'b1;
            state_d = RUN;
            ch_d    = '0;
            stg_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop = boundary && !take;

  assign x = (stg == '0) ? cap[ch] : y_chain;
  assign y = x - d_del[ch][stg];

  always_ff @(posedge clk) begin
    if (reset) begin
      y_chain <= '0;
      for (int c = 0; c < NCH; c++) begin
        cap[c]  <= '0;
        dout[c] <= '0;
        for (int k = 0; k < NSTAGES; k++) d_del[c][k] <= '0;
      end
    end else begin
      if (take) begin
        for (int c = 0; c < NCH; c++) cap[c] <= bus.integ[c*WIDTH +: WIDTH];
      end
      if (state == RUN) begin
        d_del[ch][stg] <= x;
        y_chain        <= y;
        if (stg == LAST_STG) dout[ch] <= y;
      end
    end
  end

  // Drop beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)              overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (bus.clear_overrun) overrun <= 1'b0;
  end

  always_comb begin
    bus.out_data = '0;
    for (int c = 0; c < NCH; c++) bus.out_data[c*WIDTH +: WIDTH] = dout[c];
  end

  assign bus.out_valid = (state == OUT);
  assign bus.busy      = (state != IDLE);
  assign bus.overrun   = overrun;
endmodule

// File: doc/cic_comb_scheduler.md
Name: cic_comb_scheduler

Overview:
- Decimation controller and shared comb engine for multi-channel CIC decimators, for example the I/Q pair after the mixer.
- Counts integrator-rate sample strobes and, every M-th strobe, captures all channel integrator outputs.
- Time-multiplexes a single subtractor over NCH channels × 3 comb stages, using per-channel delay state.
- Presents the decimated frame on a valid/ready output. Replaces per-channel comb hardware and the separate decimated clock.

Parameters:
- M, 8, decimation ratio (≥ 2).
- NCH, 2, number of channels sharing the comb engine (≥ 1).
- WIDTH, 24, full CIC accumulator width, i.e. input width + clog2(M**3).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  integrator section advanced this cycle (one input-rate sample).
- integ  in  NCH*WIDTH  integrator stage-3 outputs; channel c occupies bits [c*WIDTH +: WIDTH].
- out_valid  out  1  decimated frame available.
- out_ready  in  1  downstream accepts the frame.
- out_data  out  NCH*WIDTH  comb outputs, same channel packing as integ.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky flag: a decimation boundary was dropped.
- clear_overrun  in  1  clears overrun.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, phase = 0.
  - All comb delay registers d_del[c][k] = 0.
  - Capture register = 0, out_data = 0, out_valid = 0, overrun = 0, busy = 0.
  - Reset asserted mid-frame aborts the frame; no partial output is produced.
- Phase counter:
  - Increments on every in_valid, in every state, and wraps M-1 → 0.
  - A boundary is in_valid && phase == M-1.
- States and transitions: IDLE → RUN → OUT → IDLE.
  - IDLE: on a boundary, capture integ into the capture register and go to RUN with channel c = 0, stage s = 0.
  - RUN: one comb stage per cycle, with s incrementing 0 → 2 and then c incrementing.
    - Each stage computes y = x − d_del[c][s] and updates d_del[c][s] <= x.
    - For s = 0, x is the captured channel sample; for s > 0, x is y from stage s−1 of the same channel in the same frame.
    - The stage-2 result is written to out_data channel c.
    - After c = NCH−1, s = 2, go to OUT.
  - OUT: out_valid = 1. On out_valid && out_ready, go to IDLE with out_valid = 0 on the next cycle.
- Latency:
  - Boundary at cycle t → out_valid high at cycle t + 3*NCH + 1.
  - This is a non-pipelined comb chain: no extra decimated-period latency. The transfer function is (1 − z^-M)^3 at the input rate.
- Handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid never deasserts without a handshake, except on reset.
- Boundary while not IDLE:
  - In OUT with out_ready = 1 in the same cycle, the handshake completes and the new frame is captured in that cycle, going straight to RUN.
  - Otherwise the frame is dropped and overrun <= 1. Comb delay state is not updated for a dropped frame.
- clear_overrun:
  - Clears overrun next cycle.
  - If clear_overrun and a new drop occur in the same cycle, the drop wins (overrun = 1).
- Arithmetic:
  - Signed two's complement, modulo 2^WIDTH, with no saturation.
  - Wrap-around is required for CIC correctness.
- Throughput: with continuous in_valid, M ≥ 3*NCH + 2 guarantees no overrun when out_ready is tied high.

Decomposition:
- Package cic_pkg:
  - state enum (IDLE, RUN, OUT).
  - Channel-index and stage-index widths, derived from NCH and the constant NSTAGES = 3.
  - Helper function giving the CIC output width, width + $clog2(M**3).
- Sub-module cic_phase_counter: modulo-M counter with enable; outputs phase and the boundary strobe.
- Comb engine and FSM remain in the top module.

Test Plan:
- Step response (NCH=2, M=8, WIDTH=24):
  - Drive ch0 integ = 5 and ch1 = 0 at every boundary, with out_ready = 1.
  - Successive frames → ch0 = 5, −10, 5, 0, 0 …; ch1 = 0 throughout.
  - out_valid rises exactly 7 cycles after each boundary.
- Wrap-around (WIDTH=8):
  - Capture ch0 = 127, then ch0 = −128 on the next frame.
  - Frame-2 stage-0 difference = 1, computed mod 256.
  - Verify against a mod-2^8 reference model.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid.
  - out_data stays stable; the next boundary is dropped and overrun = 1.
  - The frame after release reflects no delay update for the dropped sample.
- Simultaneous accept-and-capture:
  - Boundary in the same cycle as the OUT handshake → no overrun.
  - New frame is captured; out_valid goes low for exactly 3*NCH cycles, then rises again.
- Reset mid-RUN:
  - Assert reset at RUN c = 1, s = 1.
  - Next cycle: out_valid = 0, busy = 0, phase = 0.
  - Repeat the step test → same output sequence as the first run (delays cleared).
- clear_overrun priority:
  - Assert clear_overrun in the same cycle as a drop → overrun remains 1.
  - Clear alone → overrun = 0 next cycle.
